pipeline_result_buffer: RTL and testbench

- Downstream consumer of the 3-stage add/sub pipeline. Tracks which pipeline cycles carry real operand pairs and captures the matching results into a small FIFO.
- Presents captured results on a valid/ready output interface.
- Issues credits upstream so that no in-flight result is ever dropped.
- Sits between the pipeline's result output and the next consumer (writeback/checker).

---
 rtl/pipeline_result_buffer_pkg.sv | 7 +
 rtl/pipeline_result_buffer_result_fifo.sv | 42 ++++
 rtl/pipeline_result_buffer.sv | 52 +++++
 tb/tb_pipeline_result_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipeline_result_buffer_pkg.sv
// pipeline_result_buffer_pkg: shared pipeline/result-buffer constants.
package pipeline_result_buffer_pkg;
  localparam int PIPE_LATENCY = 3;
  localparam int RESBUF_DEPTH = 4;
  localparam int RESBUF_CW = $clog2(RESBUF_DEPTH) + 1;
  typedef logic [RESBUF_CW-1:0] count_t;
endpackage

// File: rtl/pipeline_result_buffer_result_fifo.sv
// result_fifo: show-ahead FIFO with async reset, sync clear and zeroed head when empty.
module result_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DWIDTH-1:0]          data,
  output logic [DWIDTH-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       valid
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign head = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  // storage needs no reset: head is masked to zero while empty
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= data;
  assert property (@(posedge clk) disable iff (!rst) !(push && !clear && count == FULL));
endmodule

// File: rtl/pipeline_result_buffer.sv
// pipeline_result_buffer: tags accepted issues through the pipeline latency and captures results under credit control.
module pipeline_result_buffer
  import pipeline_result_buffer_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH = RESBUF_DEPTH,
  parameter int LATENCY = PIPE_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [DWIDTH-1:0]        res_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DWIDTH-1:0]        out_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int SW = $clog2(DEPTH) + 1 + $clog2(LATENCY + 1);
  logic [LATENCY-1:0] vld;
  logic [SW-1:0] inflight;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SW'(vld[i]);
  end
  // credits count both stored and in-flight results so a capture never meets a full FIFO
  assign issue_ready_o = (SW'(count_o) + inflight) < SW'(DEPTH);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      vld <= '0;
      overflow_o <= 1'b0;
    end else begin
      vld <= {vld[LATENCY-2:0], issue_valid_i & issue_ready_o};
      if (issue_valid_i && !issue_ready_o) overflow_o <= 1'b1;
    end
  result_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_i),
    .push  (vld[LATENCY-1]),
    .pop   (out_ready_i),
    .data  (res_i),
    .head  (out_data_o),
    .count (count_o),
    .valid (out_valid_o)
  );
endmodule

// File: tb/tb_pipeline_result_buffer.sv
// tb_pipeline_result_buffer: randomized scoreboard bench with a queue-based reference of outstanding issues.
module tb_pipeline_result_buffer;
  import pipeline_result_buffer_pkg::*;
  localparam int DW = 8;
  localparam int DEPTH = RESBUF_DEPTH;
  localparam int LAT = PIPE_LATENCY;
  logic clk = 0, rst = 0, clear_i = 0, issue_valid_i = 0, out_ready_i = 0;
  logic [DW-1:0] res_i = '0;
  logic issue_ready_o, out_valid_o, overflow_o;
  logic [DW-1:0] out_data_o;
  count_t count_o;
  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  int ages[$];
  logic ovf_m = 0;
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] op;
  always #5 clk = ~clk;
  pipeline_result_buffer #(.DWIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .res_i         (res_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: every accepted pop must deliver the oldest stored result
  always @(negedge clk)
    if (rst && out_valid_o && out_ready_i) begin
      checks++;
      if (exp_q.size() - ages.size() <= 0) begin
        errors++;
        $display("FAIL pop_spurious: got valid=1 data=%0h expected no stored entry at %0t", out_data_o, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", out_data_o, e, $time);
        end
      end
    end
  task automatic cycle(input bit iv, input bit ordy, input bit clr);
    int stored;
    bit rdy;
    stored = exp_q.size() - ages.size();
    rdy = exp_q.size() < DEPTH;
    chk("count", 32'(count_o), stored);
    chk("valid", 32'(out_valid_o), 32'(stored != 0));
    chk("ready", 32'(issue_ready_o), 32'(rdy));
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    if (stored == 0) chk("data_empty", 32'(out_data_o), 0);
    op = DW'($urandom);
    issue_valid_i = iv;
    out_ready_i = ordy;
    clear_i = clr;
    @(posedge clk);
    #1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = op;
    res_i = pipe[2];
    if (clr) begin
      exp_q.delete();
      ages.delete();
      ovf_m = 0;
    end else begin
      foreach (ages[i]) ages[i]++;
      while (ages.size() > 0 && ages[0] > LAT) void'(ages.pop_front());
      if (iv && rdy) begin
        exp_q.push_back(op);
        ages.push_back(1);
      end
      if (iv && !rdy) ovf_m = 1;
    end
  endtask
  task automatic mid_reset();
    #2 rst = 0;
    #1;
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_data", 32'(out_data_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    exp_q.delete();
    ages.delete();
    ovf_m = 0;
    issue_valid_i = 0;
    clear_i = 0;
    #2 rst = 1;
  endtask
  initial begin
    foreach (pipe[i]) pipe[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid_o), 0);
    chk("reset_count", 32'(count_o), 0);
    chk("reset_data", 32'(out_data_o), 0);
    chk("reset_ready", 32'(issue_ready_o), 1);
    chk("reset_overflow", 32'(overflow_o), 0);
    rst = 1;
    cycle(1, 1, 0);
    repeat (5) cycle(0, 1, 0);
    repeat (6) cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 0);
    repeat (6) cycle(0, 1, 0);
    cycle(0, 0, 1);
    repeat (12) cycle(1, 1, 0);
    repeat (4) cycle(0, 1, 0);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    cycle(0, 1, 1);
    repeat (4) cycle(0, 1, 0);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0);
    mid_reset();
    repeat (5) cycle(0, 1, 0);
    repeat (600) begin
      cycle($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 50 == 0);
      if ($urandom % 150 == 0) mid_reset();
    end
    repeat (6) cycle(0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
